// File: rtl/alu_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arb_pkg
// Shared ALU opcode encodings, the compare-op classifier and the response
// buffer state type. The ALU and the arbiter both import this package so
// that they agree on opcodes and on which opcodes produce a valid cmp flag.
// ---------------------------------------------------------------------------
package alu_share_arb_pkg;

    // Opcode width the encodings below are defined for.
    localparam int ALU_OPW = 4;

    // ALU opcode encodings.
    localparam logic [ALU_OPW-1:0] ALU_add = 4'd0;
    localparam logic [ALU_OPW-1:0] ALU_sub = 4'd1;
    localparam logic [ALU_OPW-1:0] ALU_and = 4'd2;
    localparam logic [ALU_OPW-1:0] ALU_or  = 4'd3;
    localparam logic [ALU_OPW-1:0] ALU_sll = 4'd4;
    localparam logic [ALU_OPW-1:0] ALU_srl = 4'd5;
    localparam logic [ALU_OPW-1:0] ALU_eq  = 4'd6;
    localparam logic [ALU_OPW-1:0] ALU_lt  = 4'd7;
    localparam logic [ALU_OPW-1:0] ALU_lez = 4'd8;

    // Occupancy of one response buffer.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // True for the opcodes whose cmp output is meaningful. For every other
    // opcode the ALU leaves cmp stale, so consumers must mask it.
    function automatic logic is_cmp_op(input logic [ALU_OPW-1:0] op);
        logic res;
        case (op)
            ALU_eq,
            ALU_lt,
            ALU_lez: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage : alu_share_arb_pkg

// File: rtl/alu_share_rr2.sv
// ---------------------------------------------------------------------------
// alu_share_rr2
// Two-way round-robin grant logic, purely combinational. A requester
// competes only when it is both valid and eligible; on a tie the requester
// named by prio wins. next_prio points away from whoever was granted and
// holds when nothing is granted.
// ---------------------------------------------------------------------------
module alu_share_rr2 (
    input  logic [1:0] valid,
    input  logic [1:0] eligible,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       next_prio
);

    logic [1:0] cand_s;

    // Pick at most one candidate, breaking ties with the priority pointer.
    always_comb begin
        cand_s = valid & eligible;
        case (cand_s)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Move priority to the requester that did not win; hold when idle.
    always_comb begin
        if (grant[0]) begin
            next_prio = 1'b1;
        end else if (grant[1]) begin
            next_prio = 1'b0;
        end else begin
            next_prio = prio;
        end
    end

endmodule : alu_share_rr2

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
// Shares one combinational ALU between two requesters (port 0: execute
// stage, port 1: auxiliary compare/address unit). A granted operation is
// latched into a single issue register (s1) that alone drives the ALU; one
// cycle later the ALU result is written into the owning requester's
// response buffer, which holds until the requester takes it.
//
// Optional build macro: ALU_SHARE_ARB_STATS_EN adds the grant and conflict
// counters stat_grant0, stat_grant1 and stat_conflict.
//
// OPW must be at least the package opcode width (4).
// ---------------------------------------------------------------------------
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    // requester 0
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [4:0]     req0_shamt,
    input  logic [OPW-1:0] req0_op,
    // requester 1
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [4:0]     req1_shamt,
    input  logic [OPW-1:0] req1_op,
    // response 0
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic [DW-1:0]  resp0_c,
    output logic           resp0_cmp,
    // response 1
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [DW-1:0]  resp1_c,
    output logic           resp1_cmp,
    // shared ALU
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [4:0]     alu_shamt,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_c,
    input  logic           alu_cmp
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]    stat_grant0,
    output logic [31:0]    stat_grant1,
    output logic [31:0]    stat_conflict
`endif
);

    // Port bundling
    logic [1:0]     req_valid_s;
    logic [1:0]     resp_ready_s;
    logic [1:0]     resp_valid_s;
    logic [1:0]     eligible_s;
    logic [1:0]     grant_s;
    logic           next_prio_s;

    // Operand selection for the granted requester
    logic [DW-1:0]  sel_a_s;
    logic [DW-1:0]  sel_b_s;
    logic [4:0]     sel_shamt_s;
    logic [OPW-1:0] sel_op_s;
    logic           sel_id_s;
    logic           cmp_masked_s;

    // Priority pointer and issue stage
    logic           prio_q;
    logic           s1_v_q;
    logic           s1_id_q;
    logic [DW-1:0]  s1_a_q;
    logic [DW-1:0]  s1_b_q;
    logic [4:0]     s1_shamt_q;
    logic [OPW-1:0] s1_op_q;

    // Response buffers
    buf_state_e     resp_state_q [2];
    logic [DW-1:0]  resp_c_q     [2];
    logic [1:0]     resp_cmp_q;

    assign req_valid_s  = {req1_valid, req0_valid};
    assign resp_ready_s = {resp1_ready, resp0_ready};

    // Decode buffer occupancy into per-port valid bits.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (resp_state_q[i] == BUF_FULL) begin
                resp_valid_s[i] = 1'b1;
            end else begin
                resp_valid_s[i] = 1'b0;
            end
        end
    end

    // A requester may issue only if its buffer will be free by writeback time
    // and it does not already own the operation in flight.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if ((!resp_valid_s[i] || resp_ready_s[i]) &&
                !(s1_v_q && (s1_id_q == i[0]))) begin
                eligible_s[i] = 1'b1;
            end else begin
                eligible_s[i] = 1'b0;
            end
        end
    end

    alu_share_rr2 u_rr2 (
        .valid     (req_valid_s),
        .eligible  (eligible_s),
        .prio      (prio_q),
        .grant     (grant_s),
        .next_prio (next_prio_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Route the granted requester's operation towards the issue register.
    always_comb begin
        if (grant_s[1]) begin
            sel_a_s     = req1_a;
            sel_b_s     = req1_b;
            sel_shamt_s = req1_shamt;
            sel_op_s    = req1_op;
            sel_id_s    = 1'b1;
        end else begin
            sel_a_s     = req0_a;
            sel_b_s     = req0_b;
            sel_shamt_s = req0_shamt;
            sel_op_s    = req0_op;
            sel_id_s    = 1'b0;
        end
    end

    // Keep the cmp flag only for compare opcodes; otherwise it is stale.
    always_comb begin
        if (is_cmp_op(ALU_OPW'(s1_op_q))) begin
            cmp_masked_s = alu_cmp;
        end else begin
            cmp_masked_s = 1'b0;
        end
    end

    // Issue stage, priority pointer and response buffer updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_shamt_q <= 5'd0;
            s1_op_q    <= '0;
            resp_cmp_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                resp_state_q[i] <= BUF_EMPTY;
                resp_c_q[i]     <= '0;
            end
        end else begin
            prio_q <= next_prio_s;

            // Operands are held when idle; only s1_v_q marks them stale.
            if (grant_s != 2'b00) begin
                s1_v_q     <= 1'b1;
                s1_id_q    <= sel_id_s;
                s1_a_q     <= sel_a_s;
                s1_b_q     <= sel_b_s;
                s1_shamt_q <= sel_shamt_s;
                s1_op_q    <= sel_op_s;
            end else begin
                s1_v_q <= 1'b0;
            end

            // Writeback wins over a same-cycle drain so the new result
            // replaces the consumed one and the buffer stays full.
            for (int i = 0; i < 2; i++) begin
                if (s1_v_q && (s1_id_q == i[0])) begin
                    resp_state_q[i] <= BUF_FULL;
                    resp_c_q[i]     <= alu_c;
                    resp_cmp_q[i]   <= cmp_masked_s;
                end else if (resp_valid_s[i] && resp_ready_s[i]) begin
                    resp_state_q[i] <= BUF_EMPTY;
                end else begin
                    resp_state_q[i] <= resp_state_q[i];
                end
            end
        end
    end

    assign resp0_valid = resp_valid_s[0];
    assign resp0_c     = resp_c_q[0];
    assign resp0_cmp   = resp_cmp_q[0];
    assign resp1_valid = resp_valid_s[1];
    assign resp1_c     = resp_c_q[1];
    assign resp1_cmp   = resp_cmp_q[1];

    assign alu_a     = s1_a_q;
    assign alu_b     = s1_b_q;
    assign alu_shamt = s1_shamt_q;
    assign alu_op    = s1_op_q;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [31:0] stat_grant0_q;
    logic [31:0] stat_grant1_q;
    logic [31:0] stat_conflict_q;

    // Free-running wrap-around counters of grants and two-way contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0_q   <= 32'd0;
            stat_grant1_q   <= 32'd0;
            stat_conflict_q <= 32'd0;
        end else begin
            if (grant_s[0]) begin
                stat_grant0_q <= stat_grant0_q + 32'd1;
            end
            if (grant_s[1]) begin
                stat_grant1_q <= stat_grant1_q + 32'd1;
            end
            if ((req_valid_s & eligible_s) == 2'b11) begin
                stat_conflict_q <= stat_conflict_q + 32'd1;
            end
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule : alu_share_arb
